// File: rtl/hazard_unit.sv
// RAW hazard controller for the 5-stage pipeline: 3-entry destination scoreboard, stall/bubble,
// and (with HAZARD_FORWARD_EN defined) registered EX operand forwarding selects.
module hazard_unit #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  output logic             stall,
  output logic             bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  // is_load only matters while the producer sits in EX, so older entries drop it.
  logic             ex_v_q, mem_v_q, wb_v_q;
  logic [REG_W-1:0] ex_dst_q, mem_dst_q, wb_dst_q;
  logic             ex_ld_q;
  logic [CNT_W-1:0] cnt_q;

  logic rs_chk, rt_chk;
  logic rs_ex, rs_mem, rs_wb;
  logic rt_ex, rt_mem, rt_wb;
  logic hazard, issue;

  always_comb begin
    rs_chk = id_uses_rs && (id_rs != '0);
    rt_chk = id_uses_rt && (id_rt != '0);
    rs_ex  = rs_chk && ex_v_q  && (id_rs == ex_dst_q);
    rs_mem = rs_chk && mem_v_q && (id_rs == mem_dst_q);
    rs_wb  = rs_chk && wb_v_q  && (id_rs == wb_dst_q);
    rt_ex  = rt_chk && ex_v_q  && (id_rt == ex_dst_q);
    rt_mem = rt_chk && mem_v_q && (id_rt == mem_dst_q);
    rt_wb  = rt_chk && wb_v_q  && (id_rt == wb_dst_q);
  end

`ifdef HAZARD_FORWARD_EN
  assign hazard = ex_ld_q && (rs_ex || rt_ex);
`else
  // Register file has no write-through, so a WB-stage producer still conflicts.
  assign hazard = rs_ex || rs_mem || rs_wb || rt_ex || rt_mem || rt_wb;
`endif

  assign stall  = id_valid && hazard;
  assign bubble = stall;
  assign issue  = id_valid && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_v_q    <= 1'b0;
      mem_v_q   <= 1'b0;
      wb_v_q    <= 1'b0;
      ex_dst_q  <= '0;
      mem_dst_q <= '0;
      wb_dst_q  <= '0;
      ex_ld_q   <= 1'b0;
    end else begin
      ex_v_q    <= issue && id_reg_write && (id_dst != '0);
      ex_dst_q  <= id_dst;
      ex_ld_q   <= id_mem_read;
      mem_v_q   <= ex_v_q;
      mem_dst_q <= ex_dst_q;
      wb_v_q    <= mem_v_q;
      wb_dst_q  <= mem_dst_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_count = cnt_q;

`ifdef HAZARD_FORWARD_EN
  logic [1:0] fwd_a_q, fwd_b_q;

  // Youngest producer wins.
  function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem, input logic m_wb);
    if (m_ex)       return 2'b01;
    else if (m_mem) return 2'b10;
    else if (m_wb)  return 2'b11;
    else            return 2'b00;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      fwd_a_q <= issue ? fwd_sel(rs_ex, rs_mem, rs_wb) : 2'b00;
      fwd_b_q <= issue ? fwd_sel(rt_ex, rt_mem, rt_wb) : 2'b00;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
`else
  logic unused_ex_ld;
  assign unused_ex_ld = ex_ld_q;
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; expectations follow HAZARD_FORWARD_EN if it is defined.
module tb_hazard_unit;

`ifdef HAZARD_FORWARD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic       stall, bubble;
  logic [1:0] fwd_a, fwd_b;
  logic [2:0] stall_count;

  hazard_unit #(.REG_W(5), .CNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .stall        (stall),
    .bubble       (bubble),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic [2:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         passed = 0;
  logic [2:0] cnt_model = 3'd0;

  task automatic check1(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] dst, input logic rw, input logic mr);
    id_valid = v;  id_rs = rs;   id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_dst = dst;  id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic nop();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Called at a negedge with ID inputs set; checks stall now and registered outputs after the edge.
  task automatic step(input string tag, input logic exp_stall, input logic [1:0] efa,
                      input logic [1:0] efb);
    exp_t e;
    #1;
    check1({tag, " stall"}, 8'(stall), 8'(exp_stall));
    check1({tag, " bubble"}, 8'(bubble), 8'(exp_stall));
    if (exp_stall) cnt_model = (cnt_model == 3'd7) ? 3'd7 : cnt_model + 3'd1;
    sb_q.push_back('{fa: efa, fb: efb, cnt: cnt_model});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check1({tag, " fwd_a"}, 8'(fwd_a), 8'(e.fa));
    check1({tag, " fwd_b"}, 8'(fwd_b), 8'(e.fb));
    check1({tag, " stall_count"}, 8'(stall_count), 8'(e.cnt));
    @(negedge clk);
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) begin
      nop();
      step("flush", 1'b0, 2'b00, 2'b00);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check1("reset stall", 8'(stall), 8'd0);
    check1("reset fwd_a", 8'(fwd_a), 8'd0);
    check1("reset cnt", 8'(stall_count), 8'd0);
    reset = 1'b0;
    step("idle0", 1'b0, 2'b00, 2'b00);
    step("idle1", 1'b0, 2'b00, 2'b00);

    // addi $10,$0,10 ; add $11,$12,$10
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    step("addi10", 1'b0, 2'b00, 2'b00);
    set_id(1'b1, 5'd12, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0);
    n = Fwd ? 0 : 3;
    for (int i = 0; i < n; i++) step("raw1 hold", 1'b1, 2'b00, 2'b00);
    step("raw1 issue", 1'b0, 2'b00, Fwd ? 2'b01 : 2'b00);
    check1("raw1 total", 8'(stall_count), Fwd ? 8'd0 : 8'd3);
    flush();

    // lw $16,0($10) ; add $17,$16,$16
    set_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b1);
    step("lw16", 1'b0, 2'b00, 2'b00);
    set_id(1'b1, 5'd16, 1'b1, 5'd16, 1'b1, 5'd17, 1'b1, 1'b0);
    n = Fwd ? 1 : 3;
    for (int i = 0; i < n; i++) step("lu hold", 1'b1, 2'b00, 2'b00);
    step("lu issue", 1'b0, Fwd ? 2'b10 : 2'b00, Fwd ? 2'b10 : 2'b00);
    flush();

    // addi $0,$0,5 ; add $1,$0,$0
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("addi0", 1'b0, 2'b00, 2'b00);
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0);
    step("zero src", 1'b0, 2'b00, 2'b00);

    // addi $19,$0,0x7fff ; nop ; addi $19,$19,0x6000 (counter saturates here without forwarding)
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd19, 1'b1, 1'b0);
    step("addi19", 1'b0, 2'b00, 2'b00);
    nop();
    step("nop", 1'b0, 2'b00, 2'b00);
    set_id(1'b1, 5'd19, 1'b1, 5'd0, 1'b0, 5'd19, 1'b1, 1'b0);
    n = Fwd ? 0 : 2;
    for (int i = 0; i < n; i++) step("d2 hold", 1'b1, 2'b00, 2'b00);
    step("d2 issue", 1'b0, Fwd ? 2'b10 : 2'b00, 2'b00);
    flush();

    // Invalid ID slot never stalls even with a matching source
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step("lw5", 1'b0, 2'b00, 2'b00);
    set_id(1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    step("invalid", 1'b0, 2'b00, 2'b00);
    flush();

    // Two producers, consumer reads both: rs from the younger, rt from the older
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    step("addi7", 1'b0, 2'b00, 2'b00);
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    step("addi8", 1'b0, 2'b00, 2'b00);
    set_id(1'b1, 5'd8, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
    n = Fwd ? 0 : 3;
    for (int i = 0; i < n; i++) step("two hold", 1'b1, 2'b00, 2'b00);
    step("two issue", 1'b0, Fwd ? 2'b01 : 2'b00, Fwd ? 2'b10 : 2'b00);
    flush();

    // Reset in the middle of a stall
    set_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b1);
    step("rst lw", 1'b0, 2'b00, 2'b00);
    set_id(1'b1, 5'd16, 1'b1, 5'd16, 1'b1, 5'd17, 1'b1, 1'b0);
    step("rst hold", 1'b1, 2'b00, 2'b00);
    reset = 1'b1;
    #1;
    check1("midrst stall", 8'(stall), 8'd0);
    check1("midrst bubble", 8'(bubble), 8'd0);
    check1("midrst cnt", 8'(stall_count), 8'd0);
    check1("midrst fwd_a", 8'(fwd_a), 8'd0);
    cnt_model = 3'd0;
    @(negedge clk);
    reset = 1'b0;
    step("post rst issue", 1'b0, 2'b00, 2'b00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core (IF, ID, EX, MEM, WB). It sits beside the ID stage and tracks destination registers of in-flight instructions in a 3-entry scoreboard. It asserts stall/bubble so RAW hazards resolve in hardware, replacing the hand-inserted NOPs the programs currently need. When forwarding is compiled in, it also generates the EX-stage operand forwarding selects.

## Interface
- `REG_W`, default 5: register index width.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk`  in  1: core clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high. Clears all state.
- `id_valid`  in  1: ID holds a real instruction. A NOP `32'h0` is driven as valid with `id_reg_write=0`.
- `id_rs`, `id_rt`  in  REG_W: source register indices of the ID instruction.
- `id_uses_rs`, `id_uses_rt`  in  1: the instruction actually reads rs or rt.
- `id_dst`  in  REG_W: destination register (rd for R-type, rt for addi/lw/lh/lhu).
- `id_reg_write`  in  1: the instruction writes `id_dst`.
- `id_mem_read`  in  1: the instruction is a load (lw/lh/lhu).
- `stall`  out  1: hold PC and the IF/ID register this cycle.
- `bubble`  out  1: load a NOP into ID/EX this cycle. Always equals `stall`.
- `fwd_a`, `fwd_b`  out  2: EX operand source select. 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result, 11 = WB hold register.
- `stall_count`  out  CNT_W: saturating count of stalled cycles.

## Operation
- Scoreboard: three entries, `sb_ex`, `sb_mem` and `sb_wb`. Each entry holds {valid, dst, is_load}.
- Every edge the scoreboard shifts: `sb_wb<=sb_mem`, `sb_mem<=sb_ex`.
- `sb_ex` loads {1, id_dst, id_mem_read} when `id_valid & id_reg_write & id_dst!=0 & !stall`. Otherwise it loads invalid, which models the bubble.
- Match rule for a source: the source is used, its index is nonzero, and it equals a valid entry's dst. `$0` never causes a hazard.
- Without forwarding:
  - hazard = match on rs or rt against any of `sb_ex`, `sb_mem`, `sb_wb`.
  - The register file does not write through, so an instruction still in WB conflicts.
- With forwarding: hazard = match against `sb_ex` only when `sb_ex.is_load` (load-use).
- Output rule: `stall = bubble = id_valid & hazard`.
- Forward selects, evaluated when the ID instruction issues (`id_valid & !stall`) and registered into `fwd_a`/`fwd_b`:
  - Match on `sb_ex` gives 01, `sb_mem` gives 10, `sb_wb` gives 11.
  - The youngest entry wins (ex > mem > wb). No match gives 00.
  - On a stall or with no valid issue, the selects register 00.
- `stall_count` increments on every edge with `stall=1` and holds at all-ones.

## Timing
- Reset values: all scoreboard entries invalid, `stall=bubble=0`, `fwd_a=fwd_b=00`, `stall_count=0`.
- `stall`/`bubble` are combinational from the ID inputs and scoreboard, valid in the same cycle. There is no registered latency.
- `fwd_a`/`fwd_b` have 1-cycle latency and are valid during the consumer's EX cycle.
- Without forwarding, a dependency distance of 1 stalls 3 cycles, distance 2 stalls 2 cycles, distance 3 stalls 1 cycle, and distance ≥4 stalls 0 cycles.
- With forwarding, load-use stalls exactly 1 cycle. All other RAW hazards stall 0 cycles.
- Both sources matching different entries: a stall lasts until both clear. With forwarding, each select chooses independently.
- `id_valid=0`: `stall=0` regardless of the scoreboard; the scoreboard still shifts.
- Reset asserted mid-stall: `stall` drops immediately (asynchronous clear of the scoreboard), the counter clears, and no partial state survives.

## Configuration
- `HAZARD_FORWARD_EN` defined:
  - Load-use-only stalls.
  - `fwd_a`/`fwd_b` driven as specified above.
- `HAZARD_FORWARD_EN` undefined:
  - Full interlock stalls, as specified above.
  - `fwd_a`/`fwd_b` tied to 00.
  - Forwarding select logic not instantiated.

## Test plan
- Reset, then idle for 2 cycles with `id_valid=0` → `stall=0`, `fwd=00`, `stall_count=0`.
- `addi $10,$0,10` followed immediately by `add $11,$12,$10`:
  - Without the macro: `stall=1` for exactly 3 cycles, then issue; `stall_count=3`.
  - With the macro: 0 stalls, `fwd_b=01` in the add's EX cycle.
- `lw $16,0($10)` followed by `add $17,$16,$16`:
  - With the macro: 1 stall cycle, then `fwd_a=fwd_b=10`.
  - Without the macro: 3 stall cycles.
- `addi $0,$0,5` followed by `add $1,$0,$0` → no stall, `fwd=00` in both configurations.
- `addi $19,$0,0x7fff`, then 1 NOP, then `addi $19,$19,0x6000`:
  - Without the macro: 2 stall cycles.
  - With the macro: `fwd_a=10`.
- Assert `reset` during the second cycle of a 3-cycle stall → `stall` drops to 0 the same cycle, `stall_count=0`. After release, the dependent instruction issues with no further stall.
